// File: rtl/sram_frame_writer.sv
// Streams one frame of 16-bit pixels into an asynchronous SRAM.
// Each pixel uses a WAIT -> SETUP -> STROBE write cycle into one of three frame buffers.
module sram_frame_writer #(
  parameter int unsigned FRAME_WORDS  = 307200,
  parameter logic [19:0] FRAME_STRIDE = 20'h4B000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [2:0]  frame_sel,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [18:0] LAST_COUNT = 19'(FRAME_WORDS - 1);

  logic [2:0]  state_reg, state_next;
  logic [18:0] count_reg;
  logic [19:0] base_reg;
  logic [19:0] base_sel;
  logic [19:0] addr_reg;
  logic [15:0] data_reg;
  logic        ce_n_reg, we_n_reg;
  logic        ready_reg, busy_reg, done_reg, err_reg;
  logic        start_ok, start_bad, accept, last_pixel;

  assign start_ok   = (state_reg == S_IDLE) && start && (frame_sel <= 3'd2);
  assign start_bad  = (state_reg == S_IDLE) && start && (frame_sel > 3'd2);
  assign accept     = (state_reg == S_WAIT) && pix_valid;
  assign last_pixel = (count_reg == LAST_COUNT);

  always_comb begin
    base_sel = 20'd0;
    case (frame_sel)
      3'd1:    base_sel = FRAME_STRIDE;
      3'd2:    base_sel = {FRAME_STRIDE[18:0], 1'b0};
      default: base_sel = 20'd0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start_ok) state_next = S_WAIT;
      S_WAIT:   if (pix_valid) state_next = S_SETUP;
      S_SETUP:  state_next = S_STROBE;
      S_STROBE: state_next = last_pixel ? S_DONE : S_WAIT;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // SRAM controls and status are registered from the next state so the pins come straight off flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      count_reg <= 19'd0;
      base_reg  <= 20'd0;
      addr_reg  <= 20'd0;
      data_reg  <= 16'd0;
      ce_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= start_bad;
      ready_reg <= (state_next == S_WAIT);
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_next == S_DONE);
      ce_n_reg  <= !((state_next == S_SETUP) || (state_next == S_STROBE));
      we_n_reg  <= (state_next != S_STROBE);
      if (start_ok) begin
        base_reg  <= base_sel;
        count_reg <= 19'd0;
      end
      if (accept) begin
        addr_reg <= base_reg + {1'b0, count_reg};
        data_reg <= pix_data;
      end
      if ((state_reg == S_STROBE) && !last_pixel) begin
        count_reg <= count_reg + 19'd1;
      end
    end
  end

  assign pix_ready    = ready_reg;
  assign SRAM_ADDR    = addr_reg;
  assign Data_to_SRAM = data_reg;
  assign CE           = ce_n_reg;
  assign UB           = ce_n_reg;
  assign LB           = ce_n_reg;
  assign OE           = 1'b1;
  assign WE           = we_n_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed and randomized checks of sram_frame_writer with a 4-word frame.
// Expected addresses/data come from frame_sel*stride + pixel index and the pixels the bench offered.
module tb_sram_frame_writer;

  localparam int          FW     = 4;
  localparam logic [19:0] STRIDE = 20'h4B000;

  logic        clk;
  logic        Reset;
  logic        start;
  logic [2:0]  frame_sel;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic [19:0] SRAM_ADDR;
  logic [15:0] Data_to_SRAM;
  logic        CE, UB, LB, OE, WE;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  sram_frame_writer #(
    .FRAME_WORDS (FW),
    .FRAME_STRIDE(STRIDE)
  ) dut (
    .Clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .frame_sel   (frame_sel),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .SRAM_ADDR   (SRAM_ADDR),
    .Data_to_SRAM(Data_to_SRAM),
    .CE          (CE),
    .UB          (UB),
    .LB          (LB),
    .OE          (OE),
    .WE          (WE),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares {CE,UB,LB,OE,WE,pix_ready,busy,done,err}; err is expected low here.
  task automatic chk_ctl(input string tag, input logic ce, input logic we,
                         input logic rdy, input logic bsy, input logic dn);
    chk(tag, {23'd0, CE, UB, LB, OE, WE, pix_ready, busy, done, err},
             {23'd0, ce, ce, ce, 1'b1, we, rdy, bsy, dn, 1'b0});
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (WE === 1'b0) chk("we_low_while_ready", {31'd0, pix_ready}, 32'd0);
  endtask

  // mode 0: random pixels, 1: 16'hA5A5, 2: pixel i = i+1
  task automatic run_frame(input logic [2:0] sel, input int pct, input bit poke, input int mode);
    logic [19:0] base;
    logic [15:0] pix;
    bit          v;
    bit          acc;
    int          guard;
    base = 20'(sel) * STRIDE;
    start = 1'b1;
    frame_sel = sel;
    pix_valid = 1'b0;
    step();
    start = 1'b0;
    chk_ctl($sformatf("start_f%0d", sel), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < FW; i++) begin
      case (mode)
        1:       pix = 16'hA5A5;
        2:       pix = 16'(i + 1);
        default: pix = 16'($urandom);
      endcase
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        chk_ctl($sformatf("wait_f%0d_p%0d", sel, i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        v = ($urandom_range(99) < pct);
        pix_valid = v;
        pix_data  = v ? pix : 16'($urandom);
        if (poke) begin
          start = 1'($urandom_range(1));
          frame_sel = 3'($urandom_range(7));
        end
        step();
        acc = v;
        guard++;
        if (!acc && guard > 200) begin
          chk("accept_timeout", 32'(guard), 32'd0);
          return;
        end
      end
      start = 1'b0;
      pix_valid = 1'($urandom_range(1));
      pix_data  = 16'($urandom);
      if (poke) begin
        start = 1'b1;
        frame_sel = (sel == 3'd0) ? 3'd1 : 3'd0;
      end
      chk_ctl($sformatf("setup_f%0d_p%0d", sel, i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("setup_addr_p%0d", i), 32'(SRAM_ADDR), 32'(base + 20'(i)));
      chk($sformatf("setup_data_p%0d", i), 32'(Data_to_SRAM), 32'(pix));
      step();
      start = 1'b0;
      chk_ctl($sformatf("strobe_f%0d_p%0d", sel, i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("strobe_addr_p%0d", i), 32'(SRAM_ADDR), 32'(base + 20'(i)));
      chk($sformatf("strobe_data_p%0d", i), 32'(Data_to_SRAM), 32'(pix));
      $display("write frame %0d pixel %0d addr %05h data %04h", sel, i, SRAM_ADDR, Data_to_SRAM);
      step();
      chk($sformatf("hold_addr_p%0d", i), 32'(SRAM_ADDR), 32'(base + 20'(i)));
      chk($sformatf("hold_data_p%0d", i), 32'(Data_to_SRAM), 32'(pix));
      if (i == FW - 1) begin
        chk_ctl($sformatf("done_f%0d", sel), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk_ctl($sformatf("idle_after_done_f%0d", sel), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    frame_sel = 3'd0;
    pix_valid = 1'b0;
    pix_data = 16'd0;
    step();
    step();
    chk_ctl("reset_ctl", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_addr", 32'(SRAM_ADDR), 32'd0);
    chk("reset_data", 32'(Data_to_SRAM), 32'd0);
    Reset = 1'b0;
    step();
    chk_ctl("idle_ctl", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Frame 1 with valid held high: first strobe lands 3 cycles after start.
    run_frame(3'd1, 100, 1'b0, 1);
    // Frame 0 with pixels 1..4 at addresses 0..3.
    run_frame(3'd0, 100, 1'b0, 2);

    // Invalid frame selects are rejected with a single err pulse.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      frame_sel = (k == 0) ? 3'd3 : 3'd7;
      pix_valid = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("bad_err_%0d", k), {31'd0, err}, 32'd1);
      chk($sformatf("bad_busy_%0d", k), {30'd0, busy, pix_ready}, 32'd0);
      chk($sformatf("bad_sram_%0d", k), {28'd0, CE, OE, WE, done}, 32'b1110);
      step();
      chk($sformatf("bad_err_clear_%0d", k), {31'd0, err}, 32'd0);
      chk($sformatf("bad_stay_idle_%0d", k), {28'd0, CE, WE, busy, pix_ready}, 32'b1100);
      step();
      chk($sformatf("bad_no_strobe_%0d", k), {28'd0, CE, WE, busy, err}, 32'b1100);
    end
    pix_valid = 1'b0;

    // Random frames with stalls and ignored start pulses while busy.
    for (int k = 0; k < 6; k++) begin
      run_frame(3'($urandom_range(2)), 50, 1'b1, 0);
    end

    // Reset during the strobe of the second pixel.
    start = 1'b1;
    frame_sel = 3'd0;
    pix_valid = 1'b1;
    pix_data = 16'h1111;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_p0_strobe", {12'd0, SRAM_ADDR, 1'b0, WE}, {12'd0, 20'd0, 2'b00});
    step();
    pix_data = 16'h2222;
    step();
    step();
    chk("mid_p1_strobe", {12'd0, SRAM_ADDR, 1'b0, WE}, {12'd0, 20'd1, 2'b00});
    chk("mid_p1_data", 32'(Data_to_SRAM), 32'h2222);
    Reset = 1'b1;
    step();
    chk_ctl("mid_reset_ctl", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_addr", 32'(SRAM_ADDR), 32'd0);
    chk("mid_reset_data", 32'(Data_to_SRAM), 32'd0);
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_ctl($sformatf("no_resume_%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pix_valid = 1'b0;
    run_frame(3'd2, 100, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_frame_writer.md
SRAM_FRAME_WRITER -- requirements
Module: sram_frame_writer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 307200, meaning pixels (SRAM words) per frame (640x480).
REQ-002 SHALL have parameter FRAME_STRIDE, default 20'h4B000, meaning address distance between consecutive frame buffers.
REQ-003 SHALL have one clock and a synchronous, active-high reset; the ports are named Clk and Reset.
REQ-004 Clk  input  1  system clock; all state changes on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to write one full frame.
REQ-007 frame_sel  input  3  target frame buffer: 0, 1 or 2.
REQ-008 pix_valid  input  1  pix_data is valid.
REQ-009 pix_data  input  16  pixel word to store.
REQ-010 pix_ready  output  1  writer accepts pix_data this cycle.
REQ-011 SRAM_ADDR  output  20  SRAM word address.
REQ-012 Data_to_SRAM  output  16  SRAM write data.
REQ-013 CE, UB, LB, OE, WE  output  1 each  SRAM controls, active-low.
REQ-014 busy  output  1  frame write in progress.
REQ-015 done  output  1  one-cycle pulse when the frame is complete.
REQ-016 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT, SETUP, STROBE and DONE.
REQ-018 In IDLE, start=1 with frame_sel<=2 SHALL latch base = frame_sel*FRAME_STRIDE, clear the pixel counter to 0, and go to WAIT.
REQ-019 In IDLE, start=1 with frame_sel>2 SHALL pulse err for one cycle the next cycle and remain in IDLE.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 pix_ready SHALL be 1 only in WAIT; a transfer occurs when pix_valid=1 and pix_ready=1.
REQ-022 On a transfer, the block SHALL register Data_to_SRAM=pix_data and SRAM_ADDR=base+count, then go to SETUP.
REQ-023 In SETUP: CE=0, UB=0, LB=0, OE=1, WE=1.
REQ-024 In STROBE: CE=0, UB=0, LB=0, OE=1, WE=0.
REQ-025 Address and data SHALL be stable from SETUP through the cycle after STROBE.
REQ-026 On leaving STROBE: if count==FRAME_WORDS-1, go to DONE; otherwise increment count and go to WAIT.
REQ-027 Each pixel SHALL take 3 cycles minimum (WAIT, SETUP, STROBE); there SHALL be no throughput beyond that.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-029 busy SHALL be 1 in WAIT, SETUP, STROBE and DONE, and 0 in IDLE.
REQ-030 The counter SHALL be 19 bits wide, and address arithmetic SHALL be 20 bits unsigned.
REQ-031 The maximum address SHALL be 2*FRAME_STRIDE+FRAME_WORDS-1 = 20'hE0FFF, which never wraps.
REQ-032 In IDLE, WAIT and DONE: CE=1, OE=1, WE=1, UB=1, LB=1.
REQ-033 pix_valid deasserted in WAIT SHALL stall indefinitely, with no SRAM activity and no timeout.
REQ-034 SRAM_ADDR and Data_to_SRAM SHALL hold their last value outside SETUP/STROBE.

Reset
REQ-035 Reset=1 SHALL, on the next edge, force IDLE, count=0, base=0, SRAM_ADDR=0, Data_to_SRAM=0, CE=OE=WE=UB=LB=1, pix_ready=0, busy=0, done=0 and err=0.
REQ-036 Reset SHALL take priority over all other inputs.
REQ-037 Reset asserted mid-frame (including during STROBE) SHALL deassert WE on the next edge.
REQ-038 After a mid-frame reset, there SHALL be no done pulse and no resumption; a new start is required.

Verification
REQ-039 Reset, then start with frame_sel=1 and pix_valid held 1 with pix_data=16'hA5A5 -> first write SHALL have SRAM_ADDR=20'h4B000 with WE low in the 3rd cycle after start; writes SHALL recur every 3 cycles.
REQ-040 Full frame 0 with FRAME_WORDS reduced to 4, pixels 1,2,3,4 -> writes SHALL go to addresses 0..3 with matching data, done SHALL pulse once, and busy SHALL fall the cycle after done.
REQ-041 start with frame_sel=3 -> err SHALL pulse once, busy SHALL stay 0, and there SHALL be no SRAM strobe.
REQ-042 pix_valid toggled randomly -> one write per accepted pixel, addresses contiguous, and WE SHALL never be low while pix_ready=1.
REQ-043 Reset asserted during STROBE of pixel 2 -> next cycle WE=1, busy=0 and no done; a subsequent start with frame_sel=2 SHALL write from 20'h96000.
REQ-044 start pulsed during a busy frame with a different frame_sel -> SHALL be ignored, and base and addresses SHALL be unchanged.
